isqrt_iter: RTL and testbench
=============================

# isqrt_iter

Parametrised iterative integer square-root unit: the next generation of the fixed 16-bit root datapath. It accepts an unsigned radicand of configurable width over a valid/ready handshake and computes floor(sqrt(x)) and the remainder with the digit-by-digit (restoring) algorithm, producing 1 or 2 root bits per cycle. Control and datapath are integrated in one block, and the result is held under output backpressure. It sits between the operand source and any consumer that needs root and remainder with flow control.

## Interface
- WIDTH, 16: radicand width. Must be even and ≥4.
- BITS_PER_CYCLE, 1: root bits resolved per cycle. Legal values are 1 or 2. (WIDTH/2) % BITS_PER_CYCLE must be 0.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid_i  in  1  radicand_i is valid.
- in_ready_o  out  1  block accepts an operand this cycle.
- radicand_i  in  WIDTH  unsigned operand.
- out_valid_o  out  1  root_o and rem_o are valid.
- out_ready_i  in  1  consumer accepts the result.
- root_o  out  WIDTH/2  floor(sqrt(radicand)).
- rem_o  out  WIDTH/2+1  radicand − root².
- busy_o  out  1  high while in BUSY.

## Operation
- FSM states:
  - IDLE → BUSY on accept (in_valid_i & in_ready_o).
  - BUSY → DONE when the iteration counter reaches its last step.
  - DONE → IDLE on out_ready_i & !in_valid_i.
  - DONE → BUSY on out_ready_i & in_valid_i (back-to-back accept).
- in_ready_o = (state==IDLE) | (state==DONE & out_ready_i). It is combinational from out_ready_i.
- On accept, load:
  - radicand shift register ← radicand_i
  - rem ← 0
  - root ← 0
  - counter ← K−1, where K = WIDTH/(2·BITS_PER_CYCLE).
- Per step, repeated BITS_PER_CYCLE times within one cycle:
  - rem' = (rem<<2) | next 2 MSBs of radicand
  - trial = (root<<2) | 1, WIDTH/2+2 bits
  - if rem' ≥ trial: rem ← rem' − trial and root ← (root<<1)|1
  - else: rem ← rem' and root ← root<<1
- Widths:
  - Internal rem is WIDTH/2+2 bits. The final value always fits in WIDTH/2+1 bits (max is 2·root).
  - No overflow is possible. Nothing saturates.
- In DONE:
  - root_o, rem_o and out_valid_o are registered.
  - They are stable until out_ready_i is sampled high.
- in_valid_i during BUSY is ignored because in_ready_o is low; the source must hold its operand.
- Radicand 0 completes normally in K cycles. There is no early exit.

## Timing
- Reset values:
  - state = IDLE
  - in_ready_o = 1
  - out_valid_o = 0
  - busy_o = 0
  - root_o = 0
  - rem_o = 0
- Accept at edge E0 → busy_o high after E0 through edge E0+K.
- out_valid_o rises after edge E0+K, so latency is K cycles.
  - WIDTH=16, BITS_PER_CYCLE=1: K=8.
  - WIDTH=16, BITS_PER_CYCLE=2: K=4.
- Output handshake completes at the edge where out_valid_o & out_ready_i.
  - out_valid_o falls after that edge, unless a simultaneous accept occurs; then state goes to BUSY and out_valid_o still falls.
- Sustained throughput is one result per K+1 cycles with out_ready_i tied high and back-to-back operands.
- Reset asserted mid-operation (BUSY or DONE) discards all state immediately, asynchronously.
  - No result is produced.
  - After deassertion the block is in IDLE with in_ready_o = 1.
- No combinational path from in_valid_i to any output. The only comb path is out_ready_i → in_ready_o.

## Structure
- Package isqrt_pkg:
  - state enum {IDLE, BUSY, DONE}
  - localparam helper functions: root width, rem width, iteration count K, counter width $clog2(K) (minimum 1)
- Sub-module isqrt_step:
  - Purely combinational, parametrised on WIDTH.
  - One digit step: inputs rem, root, 2 radicand bits; outputs next rem, next root.
  - Instantiated BITS_PER_CYCLE times in a chain inside isqrt_iter.
- The top holds the FSM, counter, shift register and output registers.

## Test plan
- WIDTH=16, BPC=1, radicand 0 → after 8 cycles root_o=0, rem_o=0, out_valid_o=1.
- Radicand 65535 → root_o=255, rem_o=510. Radicand 144 → root_o=12, rem_o=0. Radicand 145 → root_o=12, rem_o=1.
- Backpressure: out_ready_i low for 5 cycles after out_valid_o → outputs held constant, in_ready_o=0, a new in_valid_i is not accepted. Release → handshake in 1 cycle.
- Back-to-back: out_ready_i=1, operands 100 then 99 presented continuously → results (10,0) then (9,18), 9 cycles apart.
- Reset mid-BUSY at cycle 4 → out_valid_o never asserts for that operand. After release, in_ready_o=1, and a new operand 49 → (7,0).
- BPC=2 and WIDTH=32: radicand 0xFFFFFFFF → root 65535, rem 131070 after 8 cycles. Random sweep of both configurations checked against reference floor-sqrt.

Source files
------------

// File: rtl/isqrt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : isqrt_pkg
// Brief    : State encoding and width/iteration helpers for the iterative
//            integer square-root unit.
// Revision : 1.0 - initial release
// ============================================================================
package isqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int root_w(input int width);
        return width / 2;
    endfunction

    // Two guard bits above the root width hold the shifted partial remainder.
    function automatic int rem_w(input int width);
        return width / 2 + 2;
    endfunction

    function automatic int iter_cnt(input int width, input int bpc);
        return width / (2 * bpc);
    endfunction

    function automatic int cnt_w(input int k);
        return (k < 2) ? 1 : $clog2(k);
    endfunction

endpackage : isqrt_pkg
`default_nettype wire

// File: rtl/isqrt_step.sv
`default_nettype none
// ============================================================================
// Module   : isqrt_step
// Brief    : One combinational restoring square-root digit step.
// Revision : 1.0 - initial release
// ============================================================================
module isqrt_step
    import isqrt_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [rem_w(WIDTH)-1:0]  i_rem,
    input  logic [root_w(WIDTH)-1:0] i_root,
    input  logic [1:0]               i_bits,
    output logic [rem_w(WIDTH)-1:0]  o_rem,
    output logic [root_w(WIDTH)-1:0] o_root
);

    localparam int c_RW  = rem_w(WIDTH);
    localparam int c_RTW = root_w(WIDTH);
    localparam int c_XW  = c_RW + 2;

    logic [c_XW-1:0] w_rem_sh;
    logic [c_XW-1:0] w_trial;
    logic            w_take;

    // Compared at full shifted width; the kept result always fits c_RW bits.
    assign w_rem_sh = {i_rem, i_bits};
    assign w_trial  = {2'b00, i_root, 2'b01};
    assign w_take   = (w_rem_sh >= w_trial);

    assign o_rem  = c_RW'(w_take ? (w_rem_sh - w_trial) : w_rem_sh);
    assign o_root = {i_root[c_RTW-2:0], w_take};

endmodule : isqrt_step
`default_nettype wire

// File: rtl/isqrt_iter.sv
`default_nettype none
// ============================================================================
// Module   : isqrt_iter
// Brief    : Iterative floor(sqrt(x)) and remainder with valid/ready
//            handshakes, resolving BITS_PER_CYCLE root bits per clock.
// Revision : 1.0 - initial release
// ============================================================================
module isqrt_iter
    import isqrt_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     radicand_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH/2-1:0]   root_o,
    output logic [WIDTH/2:0]     rem_o,
    output logic                 busy_o
);

    localparam int c_RTW   = root_w(WIDTH);
    localparam int c_RW    = rem_w(WIDTH);
    localparam int c_K     = iter_cnt(WIDTH, BITS_PER_CYCLE);
    localparam int c_CW    = cnt_w(c_K);
    localparam int c_SHIFT = 2 * BITS_PER_CYCLE;

    if ((WIDTH % 2) != 0 || WIDTH < 4 ||
        (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2) ||
        ((WIDTH / 2) % BITS_PER_CYCLE) != 0) begin : g_bad_params
        $error("isqrt_iter: illegal WIDTH/BITS_PER_CYCLE combination");
    end

    state_t             r_state;
    logic [c_CW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_rad;
    logic [c_RW-1:0]    r_rem;
    logic [c_RTW-1:0]   r_root;
    logic               r_out_valid;
    logic               r_busy;

    logic [c_RW-1:0]    w_rem  [0:BITS_PER_CYCLE];
    logic [c_RTW-1:0]   w_root [0:BITS_PER_CYCLE];
    logic               w_accept;

    assign w_rem[0]  = r_rem;
    assign w_root[0] = r_root;

    // Step i consumes the radicand pair that follows the pair used by step i-1.
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        isqrt_step #(
            .WIDTH (WIDTH)
        ) u_step (
            .i_rem  (w_rem[i]),
            .i_root (w_root[i]),
            .i_bits (r_rad[WIDTH-1-2*i -: 2]),
            .o_rem  (w_rem[i+1]),
            .o_root (w_root[i+1])
        );
    end

    assign in_ready_o = (r_state == IDLE) || ((r_state == DONE) && out_ready_i);
    assign w_accept   = in_valid_i && in_ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rad       <= '0;
            r_rem       <= '0;
            r_root      <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= BUSY;
                        r_busy  <= 1'b1;
                        r_rad   <= radicand_i;
                        r_rem   <= '0;
                        r_root  <= '0;
                        r_cnt   <= c_CW'(c_K - 1);
                    end
                end
                BUSY: begin
                    r_rad  <= r_rad << c_SHIFT;
                    r_rem  <= w_rem[BITS_PER_CYCLE];
                    r_root <= w_root[BITS_PER_CYCLE];
                    r_cnt  <= r_cnt - c_CW'(1);
                    if (r_cnt == '0) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        if (in_valid_i) begin
                            r_state <= BUSY;
                            r_busy  <= 1'b1;
                            r_rad   <= radicand_i;
                            r_rem   <= '0;
                            r_root  <= '0;
                            r_cnt   <= c_CW'(c_K - 1);
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Root and remainder registers are frozen outside BUSY, so they double as outputs.
    assign root_o      = r_root;
    assign rem_o       = r_rem[c_RTW:0];
    assign out_valid_o = r_out_valid;
    assign busy_o      = r_busy;

endmodule : isqrt_iter
`default_nettype wire

// File: tb/tb_isqrt_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_isqrt_iter
// Brief    : Directed and table-driven checks of isqrt_iter in the 16/1 and
//            32/2 configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_isqrt_iter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [15:0] a_rad;
    logic [7:0]  a_root;
    logic [8:0]  a_rem;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [31:0] b_rad;
    logic [15:0] b_root;
    logic [16:0] b_rem;

    isqrt_iter #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .radicand_i(a_rad),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
        .root_o(a_root), .rem_o(a_rem), .busy_o(a_busy)
    );

    isqrt_iter #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .radicand_i(b_rad),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
        .root_o(b_root), .rem_o(b_rem), .busy_o(b_busy)
    );

    typedef struct {
        bit          sel;
        logic [31:0] x;
        logic [63:0] root;
        logic [63:0] rem;
    } vec_t;

    vec_t        vecs[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] r, m, er;
    int          lat, cyc, nres;
    logic [31:0] x;
    logic        seen;
    logic [63:0] res_root [2];
    logic [63:0] res_rem  [2];
    int          res_cyc  [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit s, input logic v, input logic [31:0] xv, input logic rdy);
        if (s) begin
            b_in_valid = v; b_rad = xv; b_out_ready = rdy;
        end else begin
            a_in_valid = v; a_rad = xv[15:0]; a_out_ready = rdy;
        end
    endtask

    // Present one operand, wait (bounded) for the result, then complete the handshake.
    task automatic run_op(input bit s, input logic [31:0] xv,
                          output logic [63:0] ro, output logic [63:0] mo, output int lt);
        drive(s, 1'b1, xv, 1'b0);
        @(posedge clk); #1;
        drive(s, 1'b0, xv, 1'b0);
        lt = 0;
        while (((s ? b_out_valid : a_out_valid) !== 1'b1) && lt < 40) begin
            @(posedge clk); #1;
            lt++;
        end
        ro = s ? 64'(b_root) : 64'(a_root);
        mo = s ? 64'(b_rem)  : 64'(a_rem);
        drive(s, 1'b0, xv, 1'b1);
        @(posedge clk); #1;
        drive(s, 1'b0, xv, 1'b0);
    endtask

    function automatic logic [63:0] ref_sqrt(input logic [63:0] xv);
        logic [63:0] acc, t;
        acc = '0;
        for (int b = 16; b >= 0; b--) begin
            t = acc | (64'd1 << b);
            if (t * t <= xv) acc = t;
        end
        return acc;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

    initial begin
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        drive(1'b1, 1'b0, 32'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_in_ready",  64'(a_in_ready),  64'd1);
        check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_busy",      64'(a_busy),      64'd0);
        check("rst_a_root",      64'(a_root),      64'd0);
        check("rst_a_rem",       64'(a_rem),       64'd0);
        check("rst_b_in_ready",  64'(b_in_ready),  64'd1);
        check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        vecs.push_back('{1'b0, 32'd0,          64'd0,     64'd0});
        vecs.push_back('{1'b0, 32'd65535,      64'd255,   64'd510});
        vecs.push_back('{1'b0, 32'd144,        64'd12,    64'd0});
        vecs.push_back('{1'b0, 32'd145,        64'd12,    64'd1});
        vecs.push_back('{1'b0, 32'd3,          64'd1,     64'd2});
        vecs.push_back('{1'b0, 32'd4,          64'd2,     64'd0});
        vecs.push_back('{1'b0, 32'd65025,      64'd255,   64'd0});
        vecs.push_back('{1'b0, 32'd65024,      64'd254,   64'd508});
        vecs.push_back('{1'b1, 32'hFFFF_FFFF,  64'd65535, 64'd131070});
        vecs.push_back('{1'b1, 32'hFFFE_0001,  64'd65535, 64'd0});
        vecs.push_back('{1'b1, 32'd1000000,    64'd1000,  64'd0});
        vecs.push_back('{1'b1, 32'd0,          64'd0,     64'd0});

        foreach (vecs[i]) begin
            run_op(vecs[i].sel, vecs[i].x, r, m, lat);
            check($sformatf("vec%0d_root", i),    r,            vecs[i].root);
            check($sformatf("vec%0d_rem", i),     m,            vecs[i].rem);
            check($sformatf("vec%0d_latency", i), 64'(lat),     64'd8);
        end

        // Busy window and backpressure hold on the 16-bit unit.
        drive(1'b0, 1'b1, 32'd144, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'd144, 1'b0);
        check("bp_busy_after_accept",   64'(a_busy),     64'd1);
        check("bp_ready_low_in_busy",   64'(a_in_ready), 64'd0);
        repeat (7) @(posedge clk);
        #1;
        check("bp_busy_before_last",    64'(a_busy),      64'd1);
        check("bp_valid_before_last",   64'(a_out_valid), 64'd0);
        @(posedge clk); #1;
        check("bp_busy_done",           64'(a_busy),      64'd0);
        check("bp_valid_done",          64'(a_out_valid), 64'd1);
        drive(1'b0, 1'b1, 32'd49, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_valid", c), 64'(a_out_valid), 64'd1);
            check($sformatf("bp_hold%0d_root", c),  64'(a_root),      64'd12);
            check($sformatf("bp_hold%0d_rem", c),   64'(a_rem),       64'd0);
            check($sformatf("bp_hold%0d_ready", c), 64'(a_in_ready),  64'd0);
            check($sformatf("bp_hold%0d_busy", c),  64'(a_busy),      64'd0);
        end
        drive(1'b0, 1'b0, 32'd49, 1'b1);
        #1;
        check("bp_ready_comb", 64'(a_in_ready), 64'd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        check("bp_valid_after_hs", 64'(a_out_valid), 64'd0);
        check("bp_idle_ready",     64'(a_in_ready),  64'd1);

        // Back-to-back operands with the consumer always ready.
        nres = 0; cyc = 0;
        drive(1'b0, 1'b1, 32'd100, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 32'd99, 1'b1);
        while (nres < 2 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (a_out_valid === 1'b1) begin
                res_root[nres] = 64'(a_root);
                res_rem[nres]  = 64'(a_rem);
                res_cyc[nres]  = cyc;
                nres++;
            end
            if (nres == 1 && a_busy === 1'b1) a_in_valid = 1'b0;
        end
        check("b2b_count", 64'(nres), 64'd2);
        if (nres == 2) begin
            check("b2b_r0_root", res_root[0], 64'd10);
            check("b2b_r0_rem",  res_rem[0],  64'd0);
            check("b2b_r1_root", res_root[1], 64'd9);
            check("b2b_r1_rem",  res_rem[1],  64'd18);
            check("b2b_spacing", 64'(res_cyc[1] - res_cyc[0]), 64'd9);
        end
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        check("b2b_final_idle", 64'(a_busy | a_out_valid), 64'd0);

        // Asynchronous reset in the middle of a computation.
        drive(1'b0, 1'b1, 32'd77, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'd77, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",     64'(a_busy),      64'd0);
        check("mid_rst_valid",    64'(a_out_valid), 64'd0);
        check("mid_rst_ready",    64'(a_in_ready),  64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (a_out_valid !== 1'b0) seen = 1'b1;
        end
        check("mid_rst_no_result", 64'(seen),       64'd0);
        check("mid_rst_idle",      64'(a_in_ready), 64'd1);
        run_op(1'b0, 32'd49, r, m, lat);
        check("post_rst_root", r, 64'd7);
        check("post_rst_rem",  m, 64'd0);

        // Random sweep of both configurations against a reference floor-sqrt.
        for (int i = 0; i < 24; i++) begin
            x = $urandom;
            if (i < 12) x = x & 32'h0000_FFFF;
            run_op(i >= 12, x, r, m, lat);
            er = ref_sqrt(64'(x));
            check($sformatf("rnd%0d_root(x=%0d)", i, x), r, er);
            check($sformatf("rnd%0d_rem(x=%0d)", i, x),  m, 64'(x) - er * er);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_isqrt_iter
`default_nettype wire
